// File: rtl/push_key_pkg.sv
// Shared definitions for the push-key front end: FSM states and 2-sample key patterns.
package push_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RPT = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_LOCK     = 2'd3
  } state_t;

  // Patterns are {older sample, newer sample}
  localparam logic [1:0] KP_PRESS   = 2'b01;
  localparam logic [1:0] KP_RELEASE = 2'b10;
  localparam logic [1:0] KP_HELD    = 2'b11;

  function automatic logic key_down(input logic [1:0] sh);
    return (sh == KP_PRESS) || (sh == KP_HELD);
  endfunction

endpackage

// File: rtl/push_tick_gen.sv
// Slow-tick prescaler: TICK is high for one CLK every TICK_DIV+1 cycles.
module push_tick_gen #(
  parameter int unsigned PRE_W    = 22,
  parameter int unsigned TICK_DIV = 3000000
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  logic [PRE_W-1:0] r_pre;
  logic             w_wrap;

  assign w_wrap = (r_pre == PRE_W'(TICK_DIV));
  assign TICK   = w_wrap;

  always_ff @(posedge CLK) begin
    if (RST)         r_pre <= '0;
    else if (w_wrap) r_pre <= '0;
    else             r_pre <= r_pre + 1'b1;
  end

endmodule

// File: rtl/push_key_ctrl.sv
// Two-key up/down counter front end: tick-sampled debounce, arbitration,
// hold-to-auto-repeat and both-key clear of the wrapping COUNT register.
module push_key_ctrl
  import push_key_pkg::*;
#(
  parameter int unsigned PRE_W     = 22,
  parameter int unsigned TICK_DIV  = 3000000,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned CNT_MAX   = 255,
  parameter int unsigned RPT_DELAY = 8,
  parameter int unsigned RPT_RATE  = 2,
  parameter int unsigned CLR_TICKS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       PUSH,
  output logic [CNT_W-1:0] COUNT,
  output logic             STEP_UP,
  output logic             STEP_DN,
  output logic             CLEARED,
  output logic             REPEATING
);

  localparam int unsigned TMR_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned CLR_W   = $clog2(CLR_TICKS + 1);

  state_t           r_state, w_state_nx;
  logic [1:0]       r_sh1, r_sh0;
  logic             r_dir;  // 1 = up
  logic [TMR_W-1:0] r_tmr, w_tmr_nx;
  logic [CLR_W-1:0] r_clr, w_clr_nx;
  logic             w_tick;
  logic             w_up_press, w_dn_press, w_up_down, w_dn_down;
  logic             w_dir_down, w_oth_down;
  logic             w_step, w_step_dir, w_dir_nx, w_clear;

  push_tick_gen #(.PRE_W(PRE_W), .TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (w_tick)
  );

  assign w_up_press = (r_sh1 == KP_PRESS);
  assign w_dn_press = (r_sh0 == KP_PRESS);
  assign w_up_down  = key_down(r_sh1);
  assign w_dn_down  = key_down(r_sh0);
  assign w_dir_down = r_dir ? w_up_down : w_dn_down;
  assign w_oth_down = r_dir ? w_dn_down : w_up_down;
  assign REPEATING  = (r_state == ST_REPEAT);

  always_ff @(posedge CLK) begin
    if (RST)         r_state <= ST_IDLE;
    else if (w_tick) r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_up_press && w_dn_press)      w_state_nx = ST_LOCK;
        else if (w_up_press || w_dn_press) w_state_nx = ST_WAIT_RPT;
      end
      ST_WAIT_RPT: begin
        if (!w_dir_down)                            w_state_nx = ST_IDLE;
        else if (w_oth_down)                        w_state_nx = ST_LOCK;
        else if (r_tmr == TMR_W'(RPT_DELAY - 1))    w_state_nx = ST_REPEAT;
      end
      ST_REPEAT: begin
        if (!w_dir_down)     w_state_nx = ST_IDLE;
        else if (w_oth_down) w_state_nx = ST_LOCK;
      end
      ST_LOCK: begin
        if (!w_up_down && !w_dn_down) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_step     = 1'b0;
    w_step_dir = r_dir;
    w_dir_nx   = r_dir;
    w_tmr_nx   = r_tmr;
    w_clr_nx   = r_clr;
    w_clear    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_up_press && w_dn_press) begin
          w_clr_nx = '0;
        end else if (w_up_press || w_dn_press) begin
          w_step     = 1'b1;
          w_step_dir = w_up_press;
          w_dir_nx   = w_up_press;
          w_tmr_nx   = '0;
        end
      end
      ST_WAIT_RPT, ST_REPEAT: begin
        if (w_dir_down) begin
          if (w_oth_down) begin
            w_clr_nx = '0;
          end else if (r_tmr == ((r_state == ST_WAIT_RPT) ? TMR_W'(RPT_DELAY - 1)
                                                          : TMR_W'(RPT_RATE - 1))) begin
            w_step   = 1'b1;
            w_tmr_nx = '0;
          end else begin
            w_tmr_nx = r_tmr + 1'b1;
          end
        end
      end
      ST_LOCK: begin
        // Saturation makes the clear fire only once per LOCK entry
        if (w_up_down && w_dn_down && (r_clr != CLR_W'(CLR_TICKS))) begin
          w_clr_nx = r_clr + 1'b1;
          w_clear  = (r_clr == CLR_W'(CLR_TICKS - 1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sh1   <= '0;
      r_sh0   <= '0;
      r_dir   <= 1'b0;
      r_tmr   <= '0;
      r_clr   <= '0;
      COUNT   <= '0;
      STEP_UP <= 1'b0;
      STEP_DN <= 1'b0;
      CLEARED <= 1'b0;
    end else begin
      STEP_UP <= 1'b0;
      STEP_DN <= 1'b0;
      CLEARED <= 1'b0;
      if (w_tick) begin
        r_sh1 <= {r_sh1[0], PUSH[1]};
        r_sh0 <= {r_sh0[0], PUSH[0]};
        r_dir <= w_dir_nx;
        r_tmr <= w_tmr_nx;
        r_clr <= w_clr_nx;
        if (w_clear) begin
          COUNT   <= '0;
          CLEARED <= 1'b1;
        end else if (w_step && w_step_dir) begin
          COUNT   <= (COUNT == CNT_W'(CNT_MAX)) ? '0 : COUNT + 1'b1;
          STEP_UP <= 1'b1;
        end else if (w_step) begin
          COUNT   <= (COUNT == '0) ? CNT_W'(CNT_MAX) : COUNT - 1'b1;
          STEP_DN <= 1'b1;
        end
      end
    end
  end

endmodule
